udp_tx_checksum_ctrl: RTL and testbench
=======================================

Name: udp_tx_checksum_ctrl

Overview:
- Store-and-forward sequencer for the 32-bit x 256-word checksum FIFO, instantiated with wr_clk = rd_clk = clk.
- Accepts one UDP payload per packet and writes it into the FIFO while accumulating the one's-complement sum over pseudo-header and payload.
- Emits the 8-byte UDP header with the final checksum, then drains the buffered payload to the IP/MAC TX path.

Parameters:
FIFO_DEPTH_WIDTH, 8, FIFO address width; capacity is 2**FIFO_DEPTH_WIDTH words (1024 payload bytes).
PROTO, 8'h11, protocol byte used in the pseudo-header.

Ports:
clk  input  1  single clock; also drives both FIFO clocks
rst_n  input  1  asynchronous active-low reset
src_ip, dst_ip  input  32 each  pseudo-header addresses; sampled on the first accepted payload beat
src_port, dst_port  input  16 each  UDP ports; sampled as above
in_data  input  32  payload beat; first byte in [31:24]
in_keep  input  4  byte valid; must be 4'hF except on the last beat, and contiguous from bit 3
in_valid / in_last  input  1 / 1  payload handshake
in_ready  output  1  beat accepted when in_valid && in_ready
out_data  output  32  header then payload
out_keep  output  4  byte valid
out_valid / out_last  output  1 / 1
out_ready  input  1
err_ovf  output  1  one-cycle pulse: packet exceeded FIFO capacity and was dropped
busy  output  1  high whenever state != IDLE
fifo_wr_en  output  1  to FIFO wr_en
fifo_wr_data  output  32  to FIFO wr_data
fifo_wr_full  input  1  from FIFO wr_full
fifo_rd_en  output  1  to FIFO rd_en
fifo_rd_data  input  32  from FIFO rd_data; valid one cycle after fifo_rd_en (no output register)
fifo_rd_empty  input  1  from FIFO rd_empty

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulators cleared.
- States: IDLE, LOAD, FOLD1, FOLD2, HDR0, HDR1, DRAIN, FLUSH.

IDLE / LOAD:
- in_ready = 1 in IDLE and in LOAD, and 0 in LOAD when fifo_wr_full.
- Each accepted beat writes the FIFO in the same cycle: fifo_wr_en = 1, fifo_wr_data = in_data with bytes outside in_keep forced to 0.
- Each accepted beat adds {data[31:16]} + {data[15:0]} (masked) into a 32-bit accumulator.
- Each accepted beat adds popcount(in_keep) to a 16-bit byte counter and 1 to a word counter.
- First beat moves IDLE to LOAD and latches ip/port fields. A single-beat packet (first beat carries in_last) goes straight to FOLD1.
- Last keep is latched on in_last.

Overflow:
- Condition: word counter reaches 2**FIFO_DEPTH_WIDTH without in_last.
- Response: pulse err_ovf, enter FLUSH.
- FLUSH: in_ready = 1 and beats are discarded through in_last; the FIFO is read out (fifo_rd_en while !fifo_rd_empty) and discarded. Return to IDLE when both are done.

Fold and checksum:
- FOLD1: udp_len = bytes + 8; add src_ip halves, dst_ip halves, {8'h00,PROTO}, udp_len twice, src_port, dst_port.
- FOLD2: fold carries twice, sum16 = s[15:0] + s[31:16] (repeat once).
- csum = ~sum16; a result of 16'h0000 is transmitted as 16'hFFFF.

Header output:
- HDR0: out_data = {src_port, dst_port}, keep F.
- HDR1: out_data = {udp_len, csum}, keep F.
- Each header word advances on out_valid && out_ready.
- Zero-length payload (single beat with keep 0 is not legal): not supported; in_keep != 0 required.

DRAIN:
- One-entry output register plus a rd_pending flag.
- fifo_rd_en = !fifo_rd_empty && words_left != 0 && (!out_valid || out_ready) && !rd_pending_unconsumed.
- Data is loaded into the output register the cycle after fifo_rd_en.
- out_last and the latched keep apply to the final word. Other words keep F.
- Return to IDLE after the last word handshakes.
- out_valid is held stable and out_data is unchanged while out_ready = 0.

Concurrency and reset:
- No new packet is accepted until IDLE: in_ready = 0 in FOLD*, HDR*, DRAIN.
- rst_n low mid-packet aborts immediately. The FIFO must be reset by the same system reset; the controller does not re-flush.

Decomposition:
- Shared package: state encoding and UDP_HDR_BYTES = 8.
- One sub-module: udp_csum_acc (32-bit accumulator with masked half-word add and two-stage fold/complement).

Test Plan:
- Single beat, data 32'h01020304, keep F, src 10.0.0.1, dst 10.0.0.2, ports 1234/5678 -> header {04D2,162E}, {000C, csum matching the software model}, payload word out_last = 1 keep F.
- 5-byte payload ending with keep 4'h8 -> udp_len 13; masked bytes contribute 0; out_keep 4'h8 on last.
- Payload whose checksum folds to 0 -> transmitted csum 16'hFFFF.
- 256-word payload with out_ready toggling every other cycle -> all 258 words in order, no duplicate or loss, out_data stable while stalled.
- 257-word payload -> err_ovf pulses once, no output beats, FIFO empty and IDLE after in_last; next packet correct.
- rst_n asserted mid-DRAIN -> all outputs 0 next edge; following packet correct.

Source files
------------

// File: rtl/udp_tx_checksum_ctrl_pkg.sv
// Shared state encoding, header size and keep helpers for the UDP TX checksum sequencer.
package udp_tx_checksum_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FOLD1,
        ST_FOLD2,
        ST_HDR0,
        ST_HDR1,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

    localparam int UDP_HDR_BYTES = 8;

    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        return 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
    endfunction

    function automatic logic [31:0] keep_mask(input logic [3:0] keep);
        return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
    endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// One's-complement accumulator: masked half-word adds per beat, one pseudo-header add,
// then a two-stage carry fold and complement registered into csum (one cycle).
module udp_csum_acc
    import udp_tx_checksum_ctrl_pkg::*;
#(
    parameter logic [7:0] PROTO = 8'h11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        beat_en,
    input  logic        beat_first,
    input  logic [31:0] beat_data,
    input  logic [3:0]  beat_keep,
    input  logic        hdr_en,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] udp_len,
    input  logic        fold_en,
    output logic [15:0] csum
);

    logic [31:0] acc;
    logic [31:0] masked;
    logic [31:0] beat_term;
    logic [31:0] hdr_term;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [15:0] csum_nxt;

    always_comb begin
        masked    = beat_data & keep_mask(beat_keep);
        beat_term = 32'(masked[31:16]) + 32'(masked[15:0]);
        // udp_len appears twice: once in the pseudo-header, once in the UDP header itself
        hdr_term  = 32'(src_ip[31:16]) + 32'(src_ip[15:0])
                  + 32'(dst_ip[31:16]) + 32'(dst_ip[15:0])
                  + 32'({8'h00, PROTO}) + 32'(udp_len) + 32'(udp_len)
                  + 32'(src_port) + 32'(dst_port);
        fold1     = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
        fold2     = fold1[15:0] + {15'h0, fold1[16]};
        csum_nxt  = ~fold2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            csum <= '0;
        end else begin
            if (beat_en) begin
                acc <= (beat_first ? 32'h0 : acc) + beat_term;
            end else if (hdr_en) begin
                acc <= acc + hdr_term;
            end
            if (fold_en) begin
                csum <= (csum_nxt == 16'h0000) ? 16'hFFFF : csum_nxt;
            end
        end
    end

endmodule

// File: rtl/udp_tx_checksum_ctrl.sv
// Store-and-forward UDP TX: buffers payload in an external FIFO while summing, then emits header + payload.
// in_ready drops on FIFO full or outside IDLE/LOAD/FLUSH; output holds data stable while out_ready is low.
module udp_tx_checksum_ctrl
    import udp_tx_checksum_ctrl_pkg::*;
#(
    parameter int         FIFO_DEPTH_WIDTH = 8,
    parameter logic [7:0] PROTO            = 8'h11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_keep,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        err_ovf,
    output logic        busy,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    input  logic        fifo_wr_full,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_rd_data,
    input  logic        fifo_rd_empty
);

    localparam logic [FIFO_DEPTH_WIDTH:0] CAP_WORDS = 1 << FIFO_DEPTH_WIDTH;

    state_t                state, state_nxt;
    logic [31:0]           src_ip_q, dst_ip_q;
    logic [15:0]           src_port_q, dst_port_q;
    logic [15:0]           byte_cnt, udp_len, csum;
    logic [FIFO_DEPTH_WIDTH:0] word_cnt, word_cnt_nxt, words_left;
    logic [3:0]            last_keep;
    logic                  in_done, rd_pending;
    logic                  oreg_vld, oreg_last;
    logic [31:0]           oreg_dat;
    logic [3:0]            oreg_keep;
    logic                  accept, first, ovf, drain_rd, out_hs, ready_raw;

    assign udp_len      = byte_cnt + 16'(UDP_HDR_BYTES);
    assign in_ready     = ready_raw & rst_n;
    assign accept       = in_valid & in_ready;
    assign first        = accept & (state == ST_IDLE);
    assign fifo_wr_en   = accept & ((state == ST_IDLE) | (state == ST_LOAD));
    assign fifo_wr_data = fifo_wr_en ? (in_data & keep_mask(in_keep)) : 32'h0;
    assign word_cnt_nxt = (first ? '0 : word_cnt) + 1'b1;
    assign ovf          = fifo_wr_en & ~in_last & (word_cnt_nxt == CAP_WORDS);
    assign drain_rd     = fifo_rd_en & (state == ST_DRAIN);
    assign out_hs       = (state == ST_DRAIN) & oreg_vld & out_ready;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nxt  = state;
        ready_raw  = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_raw = 1'b1;
                if (accept) state_nxt = ovf ? ST_FLUSH : (in_last ? ST_FOLD1 : ST_LOAD);
            end
            ST_LOAD: begin
                ready_raw = ~fifo_wr_full;
                if (accept) state_nxt = ovf ? ST_FLUSH : (in_last ? ST_FOLD1 : ST_LOAD);
            end
            ST_FOLD1: state_nxt = ST_FOLD2;
            ST_FOLD2: state_nxt = ST_HDR0;
            ST_HDR0:  if (out_ready) state_nxt = ST_HDR1;
            ST_HDR1:  if (out_ready) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                // one read in flight at a time so the output register never gets overrun
                fifo_rd_en = ~fifo_rd_empty & (words_left != '0) & (~oreg_vld | out_ready) & ~rd_pending;
                if (out_hs && oreg_last) state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                ready_raw  = 1'b1;
                fifo_rd_en = ~fifo_rd_empty;
                if ((in_done || (accept && in_last)) && fifo_rd_empty) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 32'h0;
        out_keep  = 4'h0;
        out_last  = 1'b0;
        case (state)
            ST_HDR0: begin
                out_valid = 1'b1;
                out_data  = {src_port_q, dst_port_q};
                out_keep  = 4'hF;
            end
            ST_HDR1: begin
                out_valid = 1'b1;
                out_data  = {udp_len, csum};
                out_keep  = 4'hF;
            end
            ST_DRAIN: begin
                out_valid = oreg_vld;
                out_data  = oreg_dat;
                out_keep  = oreg_keep;
                out_last  = oreg_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            words_left <= '0;
            last_keep  <= '0;
            in_done    <= 1'b0;
            rd_pending <= 1'b0;
            oreg_vld   <= 1'b0;
            oreg_last  <= 1'b0;
            oreg_dat   <= '0;
            oreg_keep  <= '0;
            err_ovf    <= 1'b0;
        end else begin
            state   <= state_nxt;
            err_ovf <= ovf;
            if (first) begin
                src_ip_q   <= src_ip;
                dst_ip_q   <= dst_ip;
                src_port_q <= src_port;
                dst_port_q <= dst_port;
            end
            if (fifo_wr_en) begin
                byte_cnt <= (first ? 16'h0 : byte_cnt) + 16'(keep_bytes(in_keep));
                word_cnt <= word_cnt_nxt;
                if (in_last) last_keep <= in_keep;
            end
            if (ovf) in_done <= 1'b0;
            else if (state == ST_FLUSH && accept && in_last) in_done <= 1'b1;
            if (state == ST_HDR1 && out_ready) words_left <= word_cnt;
            else if (drain_rd) words_left <= words_left - 1'b1;
            if (out_hs) oreg_vld <= 1'b0;
            // words_left was decremented at issue, so zero here marks the final payload word
            if (rd_pending) begin
                oreg_dat  <= fifo_rd_data;
                oreg_vld  <= 1'b1;
                oreg_last <= (words_left == '0);
                oreg_keep <= (words_left == '0) ? last_keep : 4'hF;
            end
            rd_pending <= drain_rd;
        end
    end

    udp_csum_acc #(.PROTO(PROTO)) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_en   (fifo_wr_en),
        .beat_first(first),
        .beat_data (in_data),
        .beat_keep (in_keep),
        .hdr_en    (state == ST_FOLD1),
        .src_ip    (src_ip_q),
        .dst_ip    (dst_ip_q),
        .src_port  (src_port_q),
        .dst_port  (dst_port_q),
        .udp_len   (udp_len),
        .fold_en   (state == ST_FOLD2),
        .csum      (csum)
    );

endmodule

// File: tb/tb_udp_tx_checksum_ctrl.sv
// Bench for udp_tx_checksum_ctrl: behavioural FIFO, byte-level RFC 768 checksum reference, randomized packets.
module tb_udp_tx_checksum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port;
    logic [31:0] in_data;
    logic [3:0]  in_keep;
    logic        in_valid, in_last, in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid, out_last, out_ready;
    logic        err_ovf, busy;
    logic        fifo_wr_en, fifo_wr_full, fifo_rd_en, fifo_rd_empty;
    logic [31:0] fifo_wr_data, fifo_rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ovf   = 0;
    int ff_err  = 0;
    int fcnt;
    logic [31:0] fq[$];
    logic [31:0] pay[0:299];
    logic [31:0] got_d[$];
    logic [3:0]  got_k[$];
    logic        got_l[$];

    always #5 clk = ~clk;

    udp_tx_checksum_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
        .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .err_ovf(err_ovf), .busy(busy),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty)
    );

    // 256-entry FIFO model sharing the system reset; rd_data appears the cycle after rd_en
    assign fifo_wr_full  = (fcnt >= 256);
    assign fifo_rd_empty = (fcnt == 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fcnt         <= 0;
            fifo_rd_data <= '0;
        end else begin
            if (fifo_rd_en) begin
                if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
                else ff_err++;
            end
            if (fifo_wr_en) begin
                if (fq.size() >= 256) ff_err++;
                else fq.push_back(fifo_wr_data);
            end
            fcnt <= fcnt + int'(fifo_wr_en) - int'(fifo_rd_en);
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int i);
        logic [31:0] w;
        w = pay[i / 4];
        return 8'(w >> (24 - 8 * (i % 4)));
    endfunction

    function automatic logic [3:0] keep_for(input int nb);
        int rem;
        rem = nb - 4 * (((nb + 3) / 4) - 1);
        return 4'(4'hF << (4 - rem));
    endfunction

    // one's-complement sum over pseudo-header, UDP header (checksum field zero) and payload bytes
    function automatic logic [15:0] ref_sum(input int nb);
        longint s;
        s = longint'(src_ip[31:16]) + longint'(src_ip[15:0]) + longint'(dst_ip[31:16]) + longint'(dst_ip[15:0])
          + 64'h11 + longint'(nb + 8) + longint'(src_port) + longint'(dst_port) + longint'(nb + 8);
        for (int i = 0; i < nb; i += 2)
            s += longint'({pbyte(i), (i + 1 < nb) ? pbyte(i + 1) : 8'h00});
        while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
        return 16'(s);
    endfunction

    function automatic logic [15:0] ref_csum(input int nb);
        logic [15:0] c;
        c = ~ref_sum(nb);
        return (c == 16'h0) ? 16'hFFFF : c;
    endfunction

    function automatic logic [31:0] got_word(input int i);
        return (got_d.size() > i) ? got_d[i] : 32'h0;
    endfunction

    task automatic run_pkt(input int nb, input int rmode, input int abort_at);
        int n = (nb + 3) / 4;
        int idx = 0;
        int cyc = 0;
        int budget = 30 * n + 400;
        bit done = 0;
        bit prev_stall = 0;
        logic [31:0] prev_dat = '0;
        got_d.delete(); got_k.delete(); got_l.delete();
        n_ovf = 0;
        while (!done && cyc < budget) begin
            in_valid = (idx < n) && ($urandom_range(0, 3) != 0);
            in_data  = pay[idx];
            in_last  = (idx == n - 1);
            in_keep  = (idx == n - 1) ? keep_for(nb) : 4'hF;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (err_ovf) n_ovf++;
            if (prev_stall) begin
                chk("hold_vld", out_valid, 1);
                chk("hold_dat", out_data, prev_dat);
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_k.push_back(out_keep);
                got_l.push_back(out_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
            if (abort_at > 0 && got_d.size() >= abort_at) begin
                in_valid = 1'b0;
                rst_n    = 1'b0;
                #1;
                chk("abort_ctl", {out_valid, out_last, out_keep, in_ready, err_ovf, busy, fifo_wr_en, fifo_rd_en}, 0);
                chk("abort_dat", out_data, 0);
                done = 1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (idx == n && !busy) done = 1;
        end
        in_valid = 1'b0;
        chk("done", done, 1);
    endtask

    task automatic verify(input int nb, input string tag);
        int n = (nb + 3) / 4;
        logic [31:0] w;
        chk({tag, "_cnt"}, got_d.size(), n + 2);
        chk({tag, "_hdr0"}, {got_word(0), got_k.size() > 0 ? got_k[0] : 4'h0}, {src_port, dst_port, 4'hF});
        chk({tag, "_hdr1"}, got_word(1), {16'(nb + 8), ref_csum(nb)});
        for (int j = 0; j < n && j + 2 < got_d.size(); j++) begin
            w = '0;
            for (int b = 0; b < 4; b++)
                if (4 * j + b < nb) w |= 32'(pbyte(4 * j + b)) << (24 - 8 * b);
            chk($sformatf("%s_w%0d", tag, j), {got_d[j + 2], got_k[j + 2], got_l[j + 2]},
                {w, (j == n - 1) ? keep_for(nb) : 4'hF, j == n - 1});
        end
    endtask

    task automatic fill_rand(input int nb);
        for (int i = 0; i < (nb + 3) / 4; i++) pay[i] = $urandom;
    endtask

    initial begin
        logic [15:0] s;
        int nb;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_keep = '0; in_data = '0; out_ready = 1'b0;
        src_ip = 32'h0A000001; dst_ip = 32'h0A000002; src_port = 16'd1234; dst_port = 16'd5678;
        for (int i = 0; i < 300; i++) pay[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {out_valid, out_last, out_keep, in_ready, err_ovf, busy, fifo_wr_en, fifo_rd_en}, 0);
        chk("rst_dat", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        pay[0] = 32'h01020304;
        run_pkt(4, 0, 0);
        verify(4, "t1");
        chk("t1_hdr0_const", got_word(0), 32'h04D2162E);
        chk("t1_hdr1_const", got_word(1), 32'h000CCCCD);

        fill_rand(5);
        run_pkt(5, 2, 0);
        verify(5, "t2");
        chk("t2_len", got_word(1) >> 16, 13);

        pay[0] = '0;
        s = ref_sum(4);
        pay[0] = {~s, 16'h0000};
        run_pkt(4, 0, 0);
        verify(4, "t3");
        chk("t3_csum_ffff", got_word(1) & 32'hFFFF, 32'hFFFF);

        fill_rand(1024);
        run_pkt(1024, 1, 0);
        verify(1024, "t4");

        fill_rand(1028);
        run_pkt(1028, 0, 0);
        chk("ovf_pulses", n_ovf, 1);
        chk("ovf_outs", got_d.size(), 0);
        chk("ovf_fifo_empty", fcnt, 0);
        chk("ovf_idle", busy, 0);
        fill_rand(37);
        run_pkt(37, 2, 0);
        verify(37, "t5_next");

        fill_rand(80);
        run_pkt(80, 2, 5);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        src_port = 16'hBEEF;
        fill_rand(22);
        run_pkt(22, 0, 0);
        verify(22, "t6_after_rst");

        for (int k = 0; k < 10; k++) begin
            src_ip = $urandom; dst_ip = $urandom;
            src_port = 16'($urandom); dst_port = 16'($urandom);
            nb = $urandom_range(1, 60);
            fill_rand(nb);
            run_pkt(nb, $urandom_range(0, 2), 0);
            verify(nb, $sformatf("rnd%0d", k));
        end

        chk("fifo_misuse", ff_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
